// File: rtl/restador_bin_a_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Define RESTADOR_BCD_SIGNED_EN to treat bin as two's complement and report its sign on neg.
module restador_bin_a_bcd #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           neg
);

  localparam int CW = $clog2(N + 1);

  // D digits must be able to hold every N-bit magnitude.
  if (64'(10) ** D <= 64'(2) ** N) begin : g_bad_digits
    $error("restador_bin_a_bcd: D too small for N");
  end

  // Handshake: start is sampled only in IDLE; busy is high for the N shift
  // cycles; done pulses for one cycle when bcd/neg take a new result.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   bin_q, bin_d;
  logic [4*D-1:0] scr_q, scr_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           sign_q, sign_d;
  logic           neg_q, neg_d;
  logic [N-1:0]   mag;
  logic           sign_in;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] scr_shift;

`ifdef RESTADOR_BCD_SIGNED_EN
  always_comb begin
    sign_in = bin[N-1];
    mag     = sign_in ? ((~bin) + N'(1)) : bin;
  end
  assign neg = neg_q;
`else
  always_comb begin
    sign_in = 1'b0;
    mag     = bin;
  end
  assign neg = 1'b0;
`endif

  // Per-nibble add-3 with no carry between digits.
  always_comb begin
    adj = '0;
    for (int i = 0; i < D; i++) begin
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? (scr_q[4*i +: 4] + 4'd3)
                                                 : scr_q[4*i +: 4];
    end
    scr_shift = {adj[4*D-2:0], bin_q[N-1]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = mag;
          scr_d   = '0;
          cnt_d   = CW'(N);
          sign_d  = sign_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        bin_d = {bin_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_shift;
          neg_d   = sign_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_restador_bin_a_bcd.sv
// Bench for restador_bin_a_bcd (N=8, D=3): directed handshake/reset cases plus
// random operands checked against a decimal-arithmetic reference model.
module tb_restador_bin_a_bcd;

  localparam int N = 8;
  localparam int D = 3;

`ifdef RESTADOR_BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic           neg;

  int tests = 0;
  int fails = 0;

  restador_bin_a_bcd #(.N(N), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .neg   (neg)
  );

  always #5 clk = ~clk;

  // Reference: sign and magnitude from plain integer arithmetic, digits by /10.
  function automatic logic [4*D:0] model(input logic [N-1:0] b);
    int       mag;
    bit       s;
    logic [4*D-1:0] r;
    s   = SGN && b[N-1];
    mag = s ? ((1 << N) - int'(b)) : int'(b);
    r   = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {s, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle (or in its done cycle); returns at
  // the negedge of the done cycle of this conversion.
  task automatic convert(input logic [N-1:0] v, input logic [4*D-1:0] exp_bcd,
                         input bit exp_neg, input bit glitch);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("busy_during", 32'(busy), 32'd1);
      chk("done_during", 32'(done), 32'd0);
      if (glitch && k == 2) begin
        bin   = 8'h11;
        start = 1'b1;
      end else if (glitch && k == 3) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("bcd", 32'(bcd), 32'(exp_bcd));
    chk("neg", 32'(neg), 32'(exp_neg));
  endtask

  task automatic idle_check(input logic [4*D-1:0] exp_bcd);
    start = 1'b0;
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("bcd_hold", 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    logic [N-1:0]   v;
    logic [4*D:0]   r;
    logic [4*D-1:0] last;

    // Reset with start held high: nothing may launch.
    reset = 1'b1;
    start = 1'b1;
    bin   = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    convert(8'hFE, SGN ? 12'h002 : 12'h254, SGN, 1'b0);
    idle_check(SGN ? 12'h002 : 12'h254);
    convert(8'h00, 12'h000, 1'b0, 1'b0);
    idle_check(12'h000);
    convert(8'hFF, SGN ? 12'h001 : 12'h255, SGN, 1'b0);
    idle_check(SGN ? 12'h001 : 12'h255);
    convert(8'h80, 12'h128, SGN, 1'b0);
    idle_check(12'h128);
    convert(8'h7F, 12'h127, 1'b0, 1'b0);
    idle_check(12'h127);

    // start and bin changes while busy are ignored; then back-to-back start.
    convert(8'hFE, SGN ? 12'h002 : 12'h254, SGN, 1'b1);
    convert(8'h63, 12'h099, 1'b0, 1'b0);
    idle_check(12'h099);

    // Reset sampled at E+4 aborts with no done pulse.
    bin   = 8'hC8;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    convert(8'hC8, SGN ? 12'h056 : 12'h200, SGN, 1'b0);
    idle_check(SGN ? 12'h056 : 12'h200);

    // Random operands, random ignored-start glitches and back-to-back chaining.
    last = SGN ? 12'h056 : 12'h200;
    for (int i = 0; i < 30; i++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      r = model(v);
      convert(v, r[4*D-1:0], r[4*D], 1'($urandom_range(0, 1)));
      last = r[4*D-1:0];
      if ($urandom_range(0, 1) == 1) idle_check(last);
    end
    idle_check(last);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
